// File: rtl/seg7_scan_decoder.sv
// Read-back monitor for a multiplexed 8-digit, active-low 7-segment bus.
// The asynchronous bus is synchronized and then qualified: exactly one anode
// must be low. The vector must also stay stable for a dwell before the code
// decodes it into per-digit hex/DP registers. Each digit tracks valid, error
// and staleness.
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES = 16,
    parameter int STALE_CYCLES  = 2_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [7:0]  AN,
    input  logic        CA,
    input  logic        CB,
    input  logic        CC,
    input  logic        CD,
    input  logic        CE,
    input  logic        CF,
    input  logic        CG,
    input  logic        DP,
    output logic [31:0] DIGITS,
    output logic [7:0]  DP_OUT,
    output logic [7:0]  VALID,
    output logic [7:0]  SEG_ERR,
    output logic        UPDATE,
    output logic [2:0]  UPD_IDX
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int AGE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STALE_CYCLES);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(STALE_CYCLES - 1);
    localparam logic [15:0]      IDLE_VEC = 16'hFFFF;

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } hex_t;

    // Segments are active-high here, bit 0 = a ... bit 6 = g.
    function automatic hex_t decode(input logic [6:0] seg);
        hex_t r;
        r.legal = 1'b1;
        r.value = 4'h0;
        case (seg)
            7'h3F: r.value = 4'h0;
            7'h06: r.value = 4'h1;
            7'h5B: r.value = 4'h2;
            7'h4F: r.value = 4'h3;
            7'h66: r.value = 4'h4;
            7'h6D: r.value = 4'h5;
            7'h7D: r.value = 4'h6;
            7'h07: r.value = 4'h7;
            7'h7F: r.value = 4'h8;
            7'h6F: r.value = 4'h9;
            7'h77: r.value = 4'hA;
            7'h7C: r.value = 4'hB;
            7'h39: r.value = 4'hC;
            7'h5E: r.value = 4'hD;
            7'h79: r.value = 4'hE;
            7'h71: r.value = 4'hF;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    logic [15:0]      raw_vec, sync1, sync2, last_vec;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [AGE_W-1:0] age [8];
    logic [7:0]       an_low;
    logic [6:0]       seg_on;
    logic             capturable, stable, capture, blank;
    logic [2:0]       cap_idx;
    hex_t             hex;

    assign raw_vec = {AN, DP, CG, CF, CE, CD, CC, CB, CA};

    // Two-flop synchronizer plus a one-cycle-delayed copy for change detection.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1    <= IDLE_VEC;
            sync2    <= IDLE_VEC;
            last_vec <= IDLE_VEC;
            cnt      <= '0;
        end else begin
            sync1    <= raw_vec;
            sync2    <= sync1;
            last_vec <= sync2;
            cnt      <= cnt_next;
        end
    end

    // Qualify the synced vector, run the dwell counter and pick the capture digit.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        an_low     = ~sync2[15:8];
        seg_on     = ~sync2[6:0];
        capturable = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
        stable     = (sync2 == last_vec);
        blank      = (seg_on == 7'd0);
        hex        = decode(seg_on);
        cap_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) cap_idx = 3'(i);
        end
        if (!capturable || !stable) begin
            cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
        capture = capturable && stable && (cnt == CNT_LAST);
    end

    // Per-digit result registers and age counters; a capture overrides expiry.
    // NOTE: the age array is only eight registers, not a RAM, so resetting it is intended.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            DIGITS  <= '0;
            DP_OUT  <= '0;
            VALID   <= '0;
            SEG_ERR <= '0;
            UPDATE  <= 1'b0;
            UPD_IDX <= '0;
            for (int i = 0; i < 8; i++) age[i] <= '0;
        end else begin
            UPDATE <= capture;
            if (capture) UPD_IDX <= cap_idx;
            for (int i = 0; i < 8; i++) begin
                if (capture && (cap_idx == 3'(i))) begin
                    age[i]    <= '0;
                    DP_OUT[i] <= ~sync2[7];
                    if (blank) begin
                        VALID[i]   <= 1'b0;
                        SEG_ERR[i] <= 1'b0;
                    end else if (hex.legal) begin
                        DIGITS[4*i +: 4] <= hex.value;
                        VALID[i]         <= 1'b1;
                        SEG_ERR[i]       <= 1'b0;
                    end else begin
                        VALID[i]   <= 1'b0;
                        SEG_ERR[i] <= 1'b1;
                    end
                end else begin
                    if (age[i] != AGE_MAX) age[i] <= age[i] + AGE_W'(1);
                    if (age[i] == AGE_LAST) VALID[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with SETTLE_CYCLES=4, STALE_CYCLES=100.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  an;
    logic [6:0]  seg_n;   // {CG..CA}, active-low
    logic        dp;
    logic [31:0] digits;
    logic [7:0]  dp_out, valid, seg_err;
    logic        update;
    logic [2:0]  upd_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int n_upd;

    seg7_scan_decoder #(.SETTLE_CYCLES(4), .STALE_CYCLES(100)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .AN        (an),
        .CA        (seg_n[0]),
        .CB        (seg_n[1]),
        .CC        (seg_n[2]),
        .CD        (seg_n[3]),
        .CE        (seg_n[4]),
        .CF        (seg_n[5]),
        .CG        (seg_n[6]),
        .DP        (dp),
        .DIGITS    (digits),
        .DP_OUT    (dp_out),
        .VALID     (valid),
        .SEG_ERR   (seg_err),
        .UPDATE    (update),
        .UPD_IDX   (upd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [7:0] a, input logic [6:0] s, input logic d);
        an    = a;
        seg_n = s;
        dp    = d;
    endtask

    // Hold the current bus for n edges, expecting exactly one UPDATE at edge upd_at (0 = none).
    task automatic run_dwell(input string tag, input int n, input int upd_at, input logic [2:0] idx);
        for (int e = 1; e <= n; e++) begin
            tick();
            check({tag, "_update"}, 32'(update), 32'(e == upd_at));
            if (e == upd_at) check({tag, "_upd_idx"}, 32'(upd_idx), 32'(idx));
        end
    endtask

    initial begin
        // 1: reset with idle bus
        rst_n = 1'b0;
        set_bus(8'hFF, 7'h7F, 1'b1);
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_digits",  digits,          32'h0);
        check("rst_dp_out",  32'(dp_out),     32'h0);
        check("rst_valid",   32'(valid),      32'h0);
        check("rst_seg_err", 32'(seg_err),    32'h0);
        run_dwell("idle", 10, 0, 3'd0);

        // 4: two anodes low, then no anode low: never captures
        set_bus(8'hFC, 7'b0010010, 1'b0);
        run_dwell("two_an", 50, 0, 3'd0);
        set_bus(8'hFF, 7'b0010010, 1'b0);
        run_dwell("no_an", 50, 0, 3'd0);
        check("t4_digits",  digits,       32'h0);
        check("t4_valid",   32'(valid),   32'h0);
        check("t4_seg_err", 32'(seg_err), 32'h0);
        check("t4_dp_out",  32'(dp_out),  32'h0);

        // 2: digit 0 shows "5" with DP lit; capture lands on edge 7
        set_bus(8'hFE, 7'b0010010, 1'b0);
        run_dwell("t2", 20, 7, 3'd0);
        check("t2_digit0",   32'(digits[3:0]), 32'h5);
        check("t2_valid0",   32'(valid[0]),    32'h1);
        check("t2_dp0",      32'(dp_out[0]),   32'h1);
        check("t2_seg_err0", 32'(seg_err[0]),  32'h0);

        // 3: "A" on digit 3 for only 3 cycles, then "3" held long enough
        set_bus(8'hF7, 7'b0001000, 1'b1);
        run_dwell("t3_short", 3, 0, 3'd0);
        set_bus(8'hF7, 7'b0110000, 1'b1);
        run_dwell("t3_long", 12, 7, 3'd3);
        check("t3_digit3", 32'(digits[15:12]), 32'h3);
        check("t3_valid3", 32'(valid[3]),      32'h1);
        check("t3_dp3",    32'(dp_out[3]),     32'h0);

        // 5: load "9" on digit 3, then an illegal "a only" pattern, then blank
        set_bus(8'hF7, 7'b0010000, 1'b1);
        run_dwell("t5_nine", 10, 7, 3'd3);
        check("t5_digit3_9", 32'(digits[15:12]), 32'h9);
        check("t5_valid3_9", 32'(valid[3]),      32'h1);
        set_bus(8'hF7, 7'b1111110, 1'b0);
        run_dwell("t5_err", 10, 7, 3'd3);
        check("t5_err3",        32'(seg_err[3]),     32'h1);
        check("t5_valid3_err",  32'(valid[3]),       32'h0);
        check("t5_digit3_held", 32'(digits[15:12]), 32'h9);
        check("t5_dp3_lit",     32'(dp_out[3]),      32'h1);
        set_bus(8'hF7, 7'h7F, 1'b1);
        run_dwell("t5_blank", 10, 7, 3'd3);
        check("t5_blank_err3",   32'(seg_err[3]),     32'h0);
        check("t5_blank_valid3", 32'(valid[3]),       32'h0);
        check("t5_blank_digit3", 32'(digits[15:12]), 32'h9);

        // 6a: capture "C" on digit 0, then blank the anodes and let it age out
        set_bus(8'hFE, 7'b1000110, 1'b1);
        run_dwell("t6_cap", 7, 7, 3'd0);
        set_bus(8'hFF, 7'h7F, 1'b1);
        n_upd = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (update) n_upd++;
            if (k == 99)  check("t6_valid0_k99",  32'(valid[0]), 32'h1);
            if (k == 100) check("t6_valid0_k100", 32'(valid[0]), 32'h0);
        end
        check("t6_no_update",  32'(n_upd),        32'h0);
        check("t6_digit0",     32'(digits[3:0]), 32'hC);
        check("t6_dp0",        32'(dp_out[0]),   32'h0);
        check("t6_digit3_all", 32'(digits[15:12]), 32'h9);

        // 6b: reset pulsed mid-dwell clears outputs at once; full dwell needed afterwards
        set_bus(8'hFD, 7'b1111001, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_digits",  digits,          32'h0);
        check("t6_rst_valid",   32'(valid),      32'h0);
        check("t6_rst_seg_err", 32'(seg_err),    32'h0);
        check("t6_rst_dp_out",  32'(dp_out),     32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        run_dwell("t6_post", 10, 7, 3'd1);
        check("t6_digit1", 32'(digits[7:4]), 32'h1);
        check("t6_valid1", 32'(valid[1]),    32'h1);
        check("t6_dp1",    32'(dp_out[1]),   32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
